// File: rtl/fixed_display_pkg.sv
// Shared types and constants for the Q12.4 decimal display controller.
package fixed_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_INT,
    ST_FRAC,
    ST_COMMIT
  } state_e;

  localparam int unsigned INT_ITERS  = 12;
  localparam int unsigned FRAC_ITERS = 14;
  localparam int unsigned FRAC_SCALE = 625;

  localparam int unsigned IN_W   = 16;
  localparam int unsigned INT_W  = 12;
  localparam int unsigned FRAC_W = 14;
  localparam int unsigned BCD_W  = 16;
  localparam int unsigned ITER_W = 4;
  localparam int unsigned SEG_W  = 7;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_MINUS = 7'b0111111;
  localparam logic [SEG_W-1:0] SEG_ZERO  = 7'b1000000;

  // Active-low {g,f,e,d,c,b,a} patterns for the sign and the eight digits.
  typedef struct packed {
    logic [SEG_W-1:0] sign;
    logic [SEG_W-1:0] thousand;
    logic [SEG_W-1:0] hundred;
    logic [SEG_W-1:0] ten;
    logic [SEG_W-1:0] one;
    logic [SEG_W-1:0] tenth;
    logic [SEG_W-1:0] centi;
    logic [SEG_W-1:0] milli;
    logic [SEG_W-1:0] tenth_milli;
  } seg_disp_t;

endpackage

// File: rtl/seven_segment.sv
// BCD digit to active-low seven-segment pattern {g,f,e,d,c,b,a}; non-BCD codes blank.
module seven_segment
  import fixed_display_pkg::*;
(
  input  logic [3:0]       digit,
  output logic [SEG_W-1:0] seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    case (digit)
      4'd0: seg_c = 7'b1000000;
      4'd1: seg_c = 7'b1111001;
      4'd2: seg_c = 7'b0100100;
      4'd3: seg_c = 7'b0110000;
      4'd4: seg_c = 7'b0011001;
      4'd5: seg_c = 7'b0010010;
      4'd6: seg_c = 7'b0000010;
      4'd7: seg_c = 7'b1111000;
      4'd8: seg_c = 7'b0000000;
      4'd9: seg_c = 7'b0010000;
      default: seg_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/fixed_decimal_display_ctrl.sv
// Sequential Q12.4 to 8-digit BCD converter (double-dabble) with atomically committed 7-seg outputs.
// Optional LEADING_ZERO_BLANK_EN blanks leading zeros in the thousand/hundred/ten digits.
module fixed_decimal_display_ctrl
  import fixed_display_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  in_val,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             done,
  output logic [SEG_W-1:0] seg7_neg_sign,
  output logic [SEG_W-1:0] seg7_thousand,
  output logic [SEG_W-1:0] seg7_hundred,
  output logic [SEG_W-1:0] seg7_ten,
  output logic [SEG_W-1:0] seg7_one,
  output logic [SEG_W-1:0] seg7_tenth,
  output logic [SEG_W-1:0] seg7_centi,
  output logic [SEG_W-1:0] seg7_milli,
  output logic [SEG_W-1:0] seg7_tenth_milli
);

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [SEG_W-1:0] LEAD_RST = SEG_BLANK;
`else
  localparam logic [SEG_W-1:0] LEAD_RST = SEG_ZERO;
`endif

  localparam seg_disp_t SEG_RST = '{
    sign: SEG_BLANK, thousand: LEAD_RST, hundred: LEAD_RST, ten: LEAD_RST,
    one: SEG_ZERO, tenth: SEG_ZERO, centi: SEG_ZERO, milli: SEG_ZERO,
    tenth_milli: SEG_ZERO
  };

  // Add-3 correction on every BCD nibble >= 5, done before each shift.
  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] r;
    r = bcd;
    for (int i = 0; i < 4; i++) begin
      if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  state_e              state_q, state_d;
  logic [ITER_W-1:0]   iter_q, iter_d;
  logic [INT_W-1:0]    int_sr_q, int_sr_d;
  logic [FRAC_W-1:0]   frac_sr_q, frac_sr_d;
  logic [BCD_W-1:0]    acc_q, acc_d;
  logic [BCD_W-1:0]    int_bcd_q, int_bcd_d;
  logic [BCD_W-1:0]    frac_bcd_q, frac_bcd_d;
  logic                sign_q, sign_d;
  logic                in_ready_q, in_ready_d;
  logic                done_q, done_d;
  seg_disp_t           seg_q, seg_d;

  logic [IN_W-1:0]     mag;
  logic [BCD_W-1:0]    acc_adj;
  logic [BCD_W-1:0]    acc_shift;
  logic [7:0][3:0]     digits;
  logic [7:0][SEG_W-1:0] dec_seg;

  assign digits = {int_bcd_q, frac_bcd_q};

  for (genvar g = 0; g < 8; g++) begin : g_dec
    seven_segment u_seg (
      .digit (digits[g]),
      .seg_c (dec_seg[g])
    );
  end

  always_comb begin
    state_d    = state_q;
    iter_d     = iter_q;
    int_sr_d   = int_sr_q;
    frac_sr_d  = frac_sr_q;
    acc_d      = acc_q;
    int_bcd_d  = int_bcd_q;
    frac_bcd_d = frac_bcd_q;
    sign_d     = sign_q;
    seg_d      = seg_q;
    done_d     = 1'b0;

    mag       = in_val[15] ? (16'h8000 - {1'b0, in_val[14:0]}) : in_val;
    acc_adj   = add3(acc_q);
    acc_shift = {acc_adj[BCD_W-2:0],
                 (state_q == ST_INT) ? int_sr_q[INT_W-1] : frac_sr_q[FRAC_W-1]};

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sign_d    = in_val[15];
          int_sr_d  = mag[15:4];
          frac_sr_d = FRAC_W'(mag[3:0]) * FRAC_W'(FRAC_SCALE);
          acc_d     = '0;
          iter_d    = '0;
          state_d   = ST_INT;
        end
      end
      ST_INT: begin
        acc_d    = acc_shift;
        int_sr_d = {int_sr_q[INT_W-2:0], 1'b0};
        iter_d   = iter_q + ITER_W'(1);
        if (iter_q == ITER_W'(INT_ITERS - 1)) begin
          int_bcd_d = acc_shift;
          acc_d     = '0;
          iter_d    = '0;
          state_d   = ST_FRAC;
        end
      end
      ST_FRAC: begin
        acc_d     = acc_shift;
        frac_sr_d = {frac_sr_q[FRAC_W-2:0], 1'b0};
        iter_d    = iter_q + ITER_W'(1);
        if (iter_q == ITER_W'(FRAC_ITERS - 1)) begin
          frac_bcd_d = acc_shift;
          acc_d      = '0;
          iter_d     = '0;
          state_d    = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        seg_d.sign        = sign_q ? SEG_MINUS : SEG_BLANK;
        seg_d.thousand    = dec_seg[7];
        seg_d.hundred     = dec_seg[6];
        seg_d.ten         = dec_seg[5];
        seg_d.one         = dec_seg[4];
        seg_d.tenth       = dec_seg[3];
        seg_d.centi       = dec_seg[2];
        seg_d.milli       = dec_seg[1];
        seg_d.tenth_milli = dec_seg[0];
`ifdef LEADING_ZERO_BLANK_EN
        if (int_bcd_q[15:12] == 4'd0) seg_d.thousand = SEG_BLANK;
        if (int_bcd_q[15:8] == 8'd0)  seg_d.hundred  = SEG_BLANK;
        if (int_bcd_q[15:4] == 12'd0) seg_d.ten      = SEG_BLANK;
`endif
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    in_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      iter_q     <= '0;
      int_sr_q   <= '0;
      frac_sr_q  <= '0;
      acc_q      <= '0;
      int_bcd_q  <= '0;
      frac_bcd_q <= '0;
      sign_q     <= 1'b0;
      in_ready_q <= 1'b1;
      done_q     <= 1'b0;
      seg_q      <= SEG_RST;
    end else begin
      state_q    <= state_d;
      iter_q     <= iter_d;
      int_sr_q   <= int_sr_d;
      frac_sr_q  <= frac_sr_d;
      acc_q      <= acc_d;
      int_bcd_q  <= int_bcd_d;
      frac_bcd_q <= frac_bcd_d;
      sign_q     <= sign_d;
      in_ready_q <= in_ready_d;
      done_q     <= done_d;
      seg_q      <= seg_d;
    end
  end

  assign in_ready         = in_ready_q;
  assign done             = done_q;
  assign seg7_neg_sign    = seg_q.sign;
  assign seg7_thousand    = seg_q.thousand;
  assign seg7_hundred     = seg_q.hundred;
  assign seg7_ten         = seg_q.ten;
  assign seg7_one         = seg_q.one;
  assign seg7_tenth       = seg_q.tenth;
  assign seg7_centi       = seg_q.centi;
  assign seg7_milli       = seg_q.milli;
  assign seg7_tenth_milli = seg_q.tenth_milli;

endmodule

// File: tb/tb_fixed_decimal_display_ctrl.sv
// Scoreboard bench for fixed_decimal_display_ctrl: accepted samples are modelled arithmetically and checked on done.
module tb_fixed_decimal_display_ctrl;

  typedef logic [62:0] disp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in_val;
  logic        in_valid;
  logic        in_ready;
  logic        done;
  logic [6:0]  s_sign, s_th, s_hu, s_te, s_on, s_t1, s_t2, s_t3, s_t4;

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  disp_t exp_q[$];
  int    acc_cyc_q[$];
  disp_t cur;
  disp_t rst_disp;

  fixed_decimal_display_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_val           (in_val),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .done             (done),
    .seg7_neg_sign    (s_sign),
    .seg7_thousand    (s_th),
    .seg7_hundred     (s_hu),
    .seg7_ten         (s_te),
    .seg7_one         (s_on),
    .seg7_tenth       (s_t1),
    .seg7_centi       (s_t2),
    .seg7_milli       (s_t3),
    .seg7_tenth_milli (s_t4)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Reference: signed value / 16 split into integer and 1/16 fraction, printed in decimal.
  function automatic disp_t model(input logic [15:0] v);
    int s, m, ip, fp;
    logic [6:0] sg, th, hu, te;
    s  = int'($signed(v));
    m  = (s < 0) ? -s : s;
    ip = m / 16;
    fp = (m % 16) * 625;
    sg = (s < 0) ? 7'b0111111 : 7'b1111111;
    th = seg_of(ip / 1000);
    hu = seg_of((ip / 100) % 10);
    te = seg_of((ip / 10) % 10);
`ifdef LEADING_ZERO_BLANK_EN
    if (ip < 1000) th = 7'b1111111;
    if (ip < 100)  hu = 7'b1111111;
    if (ip < 10)   te = 7'b1111111;
`endif
    return {sg, th, hu, te, seg_of(ip % 10), seg_of(fp / 1000),
            seg_of((fp / 100) % 10), seg_of((fp / 10) % 10), seg_of(fp % 10)};
  endfunction

  function automatic disp_t disp_now();
    return {s_sign, s_th, s_hu, s_te, s_on, s_t1, s_t2, s_t3, s_t4};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Stimulus-side scoreboard push on every handshake.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && in_valid && in_ready) begin
      exp_q.push_back(model(in_val));
      acc_cyc_q.push_back(cyc);
    end
  end

  // Monitor: compare on done, otherwise displays must hold the last committed value.
  always @(negedge clk) begin
    disp_t e;
    int    a;
    if (!rst_n) begin
      exp_q.delete();
      acc_cyc_q.delete();
      cur = rst_disp;
      check("reset_done", 64'(done), 64'(0));
      check("reset_ready", 64'(in_ready), 64'(1));
      check("reset_display", 64'(disp_now()), 64'(rst_disp));
    end else if (done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'(1), 64'(0));
      end else begin
        e = exp_q.pop_front();
        a = acc_cyc_q.pop_front();
        check("display", 64'(disp_now()), 64'(e));
        check("latency", 64'(cyc - a), 64'(28));
        check("ready_at_done", 64'(in_ready), 64'(1));
        cur = e;
      end
    end else begin
      check("display_hold", 64'(disp_now()), 64'(cur));
      check("in_ready", 64'(in_ready), 64'(exp_q.size() == 0));
    end
  end

  task automatic send(input logic [15:0] v, input bit drop);
    bit ok;
    ok = 1'b0;
    @(negedge clk); #1;
    in_val   = v;
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk); #1;
    end
    if (!ok) check("send_timeout", 64'(0), 64'(1));
    else @(posedge clk);
    @(negedge clk); #1;
    if (drop) in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #2;
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("idle_timeout", 64'(0), 64'(1));
  endtask

  initial begin
    rst_disp = model(16'h0000);
    cur      = rst_disp;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_val   = 16'h0000;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;

    send(16'h0000, 1'b1); wait_idle();
    send(16'h7FFF, 1'b1); wait_idle();
    send(16'h0018, 1'b1); wait_idle();
    send(16'h8000, 1'b1); wait_idle();
    send(16'hFFFF, 1'b1); wait_idle();

    // in_valid held across a conversion: second sample waits for in_ready.
    send(16'h0010, 1'b0);
    send(16'h0020, 1'b1);
    wait_idle();

    // Reset mid-conversion discards the sample; sample presented at release is taken.
    send(16'h0010, 1'b1); wait_idle();
    send(16'h0030, 1'b1);
    repeat (9) @(negedge clk);
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    in_val   = 16'h0020;
    in_valid = 1'b1;
    rst_n    = 1'b1;
    @(negedge clk); #2;
    check("accept_after_reset", 64'(exp_q.size()), 64'(1));
    in_valid = 1'b0;
    wait_idle();

    for (int n = 0; n < 40; n++) begin
      logic [15:0] v;
      int gap;
      v   = 16'($urandom);
      gap = int'($urandom_range(0, 3));
      repeat (gap) @(negedge clk);
      send(v, (n == 39) ? 1'b1 : 1'($urandom_range(0, 1)));
    end
    @(negedge clk); #1 in_valid = 1'b0;
    wait_idle();
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
